// File: rtl/odd_count_pkg.sv
// Shared types and constants for the odd up/down counter stream checker.
package odd_count_pkg;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED, FAULT} state_t;

  typedef enum logic [2:0] {UP, DN, HOLD, JUMP, BADCODE} step_t;

  localparam logic [3:0] STEP_UP = 4'd2;
  localparam logic [3:0] STEP_DN = 4'd14;
  localparam logic [3:0] WRAP_HI = 4'd15;
  localparam logic [3:0] WRAP_LO = 4'd1;

endpackage

// File: rtl/odd_step_classify.sv
// Classifies the step from the previous legal sample p to the current sample c.
module odd_step_classify
  import odd_count_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] c,
  output step_t      step,
  output logic       wrap_up,
  output logic       wrap_dn
);

  logic [3:0] d;

  // Modulo-16 distance; natural 4-bit wrap gives 15->1 as +2 and 1->15 as -2.
  assign d = c - p;

  always_comb begin
    step = JUMP;
    if (!c[0])               step = BADCODE;
    else if (d == STEP_UP)   step = UP;
    else if (d == STEP_DN)   step = DN;
    else if (d == 4'd0)      step = HOLD;
  end

  assign wrap_up = (step == UP) && (p == WRAP_HI) && (c == WRAP_LO);
  assign wrap_dn = (step == DN) && (p == WRAP_LO) && (c == WRAP_HI);

endmodule

// File: rtl/odd_count_monitor.sv
// Receive-side checker: recovers index/direction from the odd-code count bus
// and tracks lock, error count and sticky fault.
module odd_count_monitor
  import odd_count_pkg::*;
#(
  parameter int LOCK_LEN  = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       count_valid,
  input  logic [3:0] count_in,
  input  logic       clear,
  output logic [2:0] index_out,
  output logic       dir,
  output logic       locked,
  output logic       step_err,
  output logic       wrap_up,
  output logic       wrap_dn,
  output logic       fault,
  output logic [3:0] err_count
);

  localparam logic [3:0] LOCK_LEN_4  = 4'(LOCK_LEN);
  localparam logic [3:0] ERR_LIMIT_4 = 4'(ERR_LIMIT);

  state_t     state;
  logic [3:0] p_q;
  logic [3:0] run_cnt;
  step_t      step;
  logic       cls_wrap_up;
  logic       cls_wrap_dn;
  logic       is_err;
  logic [3:0] err_next;
  logic [3:0] run_next;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  odd_step_classify u_classify (
    .p       (p_q),
    .c       (count_in),
    .step    (step),
    .wrap_up (cls_wrap_up),
    .wrap_dn (cls_wrap_dn)
  );

  always_comb begin
    is_err = 1'b0;
    case (state)
      HUNT:    is_err = !count_in[0];
      SYNC:    is_err = (step == JUMP) || (step == BADCODE);
      LOCKED:  is_err = (step == HOLD) || (step == JUMP) || (step == BADCODE);
      default: is_err = 1'b0;
    endcase
  end

  assign err_next = sat_inc(err_count);
  assign run_next = run_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      p_q       <= 4'd0;
      run_cnt   <= 4'd0;
      index_out <= 3'd0;
      dir       <= 1'b1;
      locked    <= 1'b0;
      step_err  <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      fault     <= 1'b0;
      err_count <= 4'd0;
    end else begin
      step_err <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      if (clear) begin
        state     <= HUNT;
        run_cnt   <= 4'd0;
        err_count <= 4'd0;
        locked    <= 1'b0;
        fault     <= 1'b0;
      end else if (count_valid && (state != FAULT)) begin
        if (count_in[0]) index_out <= count_in[3:1];
        if (is_err) begin
          step_err  <= 1'b1;
          err_count <= err_next;
        end
        // Reaching the error limit overrides whatever move the error would cause.
        if (is_err && (err_next >= ERR_LIMIT_4)) begin
          state  <= FAULT;
          fault  <= 1'b1;
          locked <= 1'b0;
        end else begin
          case (state)
            HUNT: begin
              if (count_in[0]) begin
                p_q     <= count_in;
                run_cnt <= 4'd0;
                state   <= SYNC;
              end
            end
            SYNC: begin
              case (step)
                UP, DN: begin
                  p_q     <= count_in;
                  dir     <= (step == UP);
                  wrap_up <= cls_wrap_up;
                  wrap_dn <= cls_wrap_dn;
                  if (run_next == LOCK_LEN_4) begin
                    state   <= LOCKED;
                    locked  <= 1'b1;
                    run_cnt <= 4'd0;
                  end else begin
                    run_cnt <= run_next;
                  end
                end
                JUMP: begin
                  p_q     <= count_in;
                  run_cnt <= 4'd0;
                end
                BADCODE: begin
                  state   <= HUNT;
                  run_cnt <= 4'd0;
                end
                default: ;
              endcase
            end
            LOCKED: begin
              case (step)
                UP, DN: begin
                  p_q     <= count_in;
                  dir     <= (step == UP);
                  wrap_up <= cls_wrap_up;
                  wrap_dn <= cls_wrap_dn;
                end
                HOLD, JUMP: begin
                  state   <= SYNC;
                  p_q     <= count_in;
                  run_cnt <= 4'd0;
                  locked  <= 1'b0;
                end
                BADCODE: begin
                  state   <= HUNT;
                  run_cnt <= 4'd0;
                  locked  <= 1'b0;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_odd_count_monitor.sv
// Directed bench for odd_count_monitor with hand-computed expectations.
module tb_odd_count_monitor;

  logic       clk;
  logic       reset;
  logic       count_valid;
  logic [3:0] count_in;
  logic       clear;
  logic [2:0] index_out;
  logic       dir;
  logic       locked;
  logic       step_err;
  logic       wrap_up;
  logic       wrap_dn;
  logic       fault;
  logic [3:0] err_count;

  int checks = 0;
  int errors = 0;

  odd_count_monitor #(.LOCK_LEN(4), .ERR_LIMIT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_valid (count_valid),
    .count_in    (count_in),
    .clear       (clear),
    .index_out   (index_out),
    .dir         (dir),
    .locked      (locked),
    .step_err    (step_err),
    .wrap_up     (wrap_up),
    .wrap_dn     (wrap_dn),
    .fault       (fault),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] v);
    count_in    = v;
    count_valid = 1'b1;
    @(posedge clk);
    #1;
    count_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_index"}, 32'(index_out), 0);
    check_val({tag, "_dir"},   32'(dir),       1);
    check_val({tag, "_locked"},32'(locked),    0);
    check_val({tag, "_serr"},  32'(step_err),  0);
    check_val({tag, "_wup"},   32'(wrap_up),   0);
    check_val({tag, "_wdn"},   32'(wrap_dn),   0);
    check_val({tag, "_fault"}, 32'(fault),     0);
    check_val({tag, "_errc"},  32'(err_count), 0);
  endtask

  initial begin
    reset = 1'b0;
    count_valid = 1'b0;
    count_in = 4'd0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    idle();

    // Acquire lock on an up stream with the repeated first value.
    send(4'd1); send(4'd1); send(4'd3); send(4'd5); send(4'd7);
    check_val("pre_lock", 32'(locked), 0);
    send(4'd9);
    check_val("lock", 32'(locked), 1);
    check_val("lock_dir", 32'(dir), 1);
    check_val("lock_idx", 32'(index_out), 4);
    check_val("lock_errc", 32'(err_count), 0);

    // Up wrap 15 -> 1.
    send(4'd11); send(4'd13); send(4'd15);
    check_val("pre_wrap_up", 32'(wrap_up), 0);
    send(4'd1);
    check_val("wrap_up", 32'(wrap_up), 1);
    check_val("wrap_up_dir", 32'(dir), 1);
    check_val("wrap_up_serr", 32'(step_err), 0);
    check_val("wrap_up_idx", 32'(index_out), 0);
    idle();
    check_val("wrap_up_gone", 32'(wrap_up), 0);
    send(4'd3); send(4'd5); send(4'd7);

    // Reversal and down wrap 1 -> 15.
    send(4'd5);
    check_val("rev_dir", 32'(dir), 0);
    check_val("rev_locked", 32'(locked), 1);
    check_val("rev_serr", 32'(step_err), 0);
    send(4'd3); send(4'd1);
    check_val("pre_wrap_dn", 32'(wrap_dn), 0);
    send(4'd15);
    check_val("wrap_dn", 32'(wrap_dn), 1);
    check_val("wrap_dn_locked", 32'(locked), 1);
    check_val("wrap_dn_idx", 32'(index_out), 7);
    send(4'd1);
    check_val("wrap_dn_gone", 32'(wrap_dn), 0);
    check_val("rev_up_dir", 32'(dir), 1);
    send(4'd3); send(4'd5);

    // JUMP while locked, then BADCODE.
    send(4'd9);
    check_val("jump_serr", 32'(step_err), 1);
    check_val("jump_locked", 32'(locked), 0);
    check_val("jump_errc", 32'(err_count), 1);
    check_val("jump_idx", 32'(index_out), 4);
    send(4'd4);
    check_val("bad_serr", 32'(step_err), 1);
    check_val("bad_errc", 32'(err_count), 2);
    check_val("bad_idx", 32'(index_out), 4);
    // In HUNT an odd sample captures without error; a repeat is a tolerated HOLD.
    send(4'd3);
    check_val("hunt_cap_serr", 32'(step_err), 0);
    check_val("hunt_cap_idx", 32'(index_out), 1);
    send(4'd3);
    check_val("sync_hold_serr", 32'(step_err), 0);
    check_val("sync_hold_errc", 32'(err_count), 2);

    // Third error drives FAULT; later samples are ignored.
    send(4'd8);
    check_val("fault", 32'(fault), 1);
    check_val("fault_errc", 32'(err_count), 3);
    check_val("fault_serr", 32'(step_err), 1);
    send(4'd5);
    check_val("fault_ign_idx", 32'(index_out), 1);
    check_val("fault_ign_serr", 32'(step_err), 0);
    check_val("fault_ign_errc", 32'(err_count), 3);
    send(4'd6);
    check_val("fault_ign2_errc", 32'(err_count), 3);
    check_val("fault_sticky", 32'(fault), 1);

    // Clear with a concurrent sample: sample discarded.
    clear = 1'b1;
    send(4'd7);
    clear = 1'b0;
    check_val("clr_fault", 32'(fault), 0);
    check_val("clr_errc", 32'(err_count), 0);
    check_val("clr_idx", 32'(index_out), 1);
    check_val("clr_serr", 32'(step_err), 0);
    // HUNT after clear: even sample errors and stays in HUNT.
    send(4'd2);
    check_val("hunt_even_serr", 32'(step_err), 1);
    check_val("hunt_even_errc", 32'(err_count), 1);
    send(4'd3); send(4'd5); send(4'd7); send(4'd9);
    check_val("relock_pre", 32'(locked), 0);
    send(4'd11);
    check_val("relock", 32'(locked), 1);
    check_val("relock_errc", 32'(err_count), 1);
    check_val("relock_idx", 32'(index_out), 5);

    // Asynchronous reset mid-LOCKED with a valid sample pending.
    count_in = 4'd13;
    count_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_val("rst_hold_locked", 32'(locked), 0);
    count_valid = 1'b0;
    #2;
    reset = 1'b1;
    idle();
    send(4'd1); send(4'd3); send(4'd5); send(4'd7);
    check_val("post_rst_pre", 32'(locked), 0);
    send(4'd9);
    check_val("post_rst_lock", 32'(locked), 1);
    check_val("post_rst_errc", 32'(err_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/odd_count_monitor.md
# odd_count_monitor

Receive-side checker for the odd up/down counter stream. Samples the 4-bit odd-code count bus with a valid strobe and recovers the 3-bit index and the counting direction. Flags illegal codes and illegal steps, and tracks lock and fault status. It sits on the consumer side of the counter and feeds status and error indications to system control.

## Interface
- LOCK_LEN, 4: consecutive legal up/down steps required to enter LOCKED (1..15)
- ERR_LIMIT, 3: errors counted before sticky FAULT (1..15)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- count_valid  in  1  count_in is sampled this cycle
- count_in  in  4  odd-code count (legal values 1,3,...,15)
- clear  in  1  synchronous clear of fault, error count and state
- index_out  out  3  decoded index of last legal sample (count_in >> 1)
- dir  out  1  last observed direction, 1 = up, 0 = down
- locked  out  1  high while in LOCKED
- step_err  out  1  one-cycle pulse per detected error
- wrap_up  out  1  one-cycle pulse on legal step 15 -> 1
- wrap_dn  out  1  one-cycle pulse on legal step 1 -> 15
- fault  out  1  high while in FAULT
- err_count  out  4  errors since reset/clear, saturates at 15

## Operation
- Step classification, with previous legal sample p, current sample c, and d = (c - p) mod 16 (4-bit wrap):
  - BADCODE when c[0] == 0.
  - UP when d == 2.
  - DN when d == 14.
  - HOLD when d == 0.
  - JUMP for any other d.
- States:
  - HUNT: no previous sample. An odd sample captures p and goes to SYNC with run count = 0. An even sample is an error; stay in HUNT.
  - SYNC: UP/DN increment the run count, update dir and p. HOLD is tolerated with no change; this absorbs the counter's repeated first value after reset. JUMP is an error: run count = 0, p <= c, stay in SYNC. BADCODE is an error and goes to HUNT. When the run count reaches LOCK_LEN, go to LOCKED.
  - LOCKED: UP/DN update dir and p. A reversal is legal. HOLD or JUMP is an error and goes to SYNC with p <= c and run count 0. BADCODE is an error and goes to HUNT.
  - FAULT: entered when err_count reaches ERR_LIMIT, from any state, taking priority over the transition the error would otherwise cause. Sticky; samples are ignored.
- Errors: each error pulses step_err and increments err_count (saturating at 15).
- index_out updates on every legal (odd) sample taken outside FAULT.
- Wrap pulses fire only on UP/DN steps.
- count_valid low: no state, counter or output change; all pulses low.
- clear in any state: go to HUNT, err_count = 0, run count = 0. A sample in the same cycle is discarded.
- Reset values: HUNT; index_out 0, dir 1, locked 0, step_err 0, wrap_up 0, wrap_dn 0, fault 0, err_count 0, run count 0.

## Timing
- All outputs are registered. A response appears one cycle after the sampling edge.
- locked rises on the edge that accepts the LOCK_LEN-th consecutive legal step.
- locked falls on the edge that accepts the first error.
- fault rises on the same edge where err_count reaches ERR_LIMIT.
- step_err and the wrap pulses last exactly one cycle per sample. Back-to-back bad samples give back-to-back pulses.
- Asynchronous reset takes effect immediately, mid-run or mid-FAULT. The first valid sample after deassertion is treated as a HUNT sample.

## Structure
- Shared package odd_count_pkg holds:
  - state enum {HUNT, SYNC, LOCKED, FAULT}
  - step enum {UP, DN, HOLD, JUMP, BADCODE}
  - constants STEP_UP = 4'd2, STEP_DN = 4'd14, WRAP_HI = 4'd15, WRAP_LO = 4'd1
- One combinational sub-module, odd_step_classify: inputs p and c, outputs the step enum plus wrap_up/wrap_dn qualifiers.
- The top level holds the FSM, run counter, error counter and output registers.

## Test plan
- Reset, then valid samples 1,1,3,5,7,9 -> HOLD tolerated; locked = 1 one cycle after the sample 9, dir = 1, index_out = 4, err_count = 0.
- Locked up-stream 13,15,1,3 -> wrap_up pulse one cycle after sample 1; dir stays 1; no step_err.
- Locked stream 7,5,3,1,15 -> dir = 0 after 5; wrap_dn pulse after 15; locked stays 1.
- Locked at 5, then sample 9 (JUMP) -> step_err pulse, locked = 0, err_count = 1, state SYNC. Then sample 4 (BADCODE) -> err_count = 2, state HUNT, index_out unchanged.
- Three errors with ERR_LIMIT = 3 -> fault = 1 on the third error; later samples ignored. clear with count_valid = 1 -> fault = 0, err_count = 0, HUNT, sample discarded.
- Assert reset mid-LOCKED with count_valid = 1 -> all outputs return to reset values immediately; relock requires LOCK_LEN fresh steps.
